// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, function codes, ALU op codes, datapath select
// encodings and multicycle controller state codes.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_R     = 4'd7,
      S_WB_I     = 4'd8,
      S_WB_MEM   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   typedef enum logic [2:0] {
      IC_RTYPE,
      IC_ITYPE,
      IC_MEM,
      IC_BRANCH,
      IC_JUMP,
      IC_ILLEGAL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_SYSCALL = 6'b001100;

   // ALU codes reuse the R-type func values so EXEC_R can pass func straight through.
   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_ADDU = 6'b100001;
   localparam logic [5:0] ALU_SUB  = 6'b100010;
   localparam logic [5:0] ALU_AND  = 6'b100100;
   localparam logic [5:0] ALU_OR   = 6'b100101;
   localparam logic [5:0] ALU_XOR  = 6'b100110;
   localparam logic [5:0] ALU_SLT  = 6'b101010;
   localparam logic [5:0] ALU_LUI  = 6'b001111;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   localparam logic       SRC_A_PC = 1'b0;
   localparam logic       SRC_A_RS = 1'b1;

   localparam logic [1:0] SRC_B_RT      = 2'd0;
   localparam logic [1:0] SRC_B_FOUR    = 2'd1;
   localparam logic [1:0] SRC_B_IMM     = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   function automatic iclass_t classify(input logic [5:0] op);
      case (op)
         OP_RTYPE:                                 return IC_RTYPE;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
         OP_ORI, OP_XORI, OP_LUI:                  return IC_ITYPE;
         OP_LB, OP_LW, OP_SB, OP_SW:               return IC_MEM;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
         OP_REGIMM:                                return IC_BRANCH;
         OP_J, OP_JAL:                             return IC_JUMP;
         default:                                  return IC_ILLEGAL;
      endcase
   endfunction

   function automatic logic [5:0] itype_alu_op(input logic [5:0] op);
      case (op)
         OP_ADDI:  return ALU_ADD;
         OP_ADDIU: return ALU_ADDU;
         OP_ANDI:  return ALU_AND;
         OP_ORI:   return ALU_OR;
         OP_XORI:  return ALU_XOR;
         OP_SLTI:  return ALU_SLT;
         OP_LUI:   return ALU_LUI;
         default:  return ALU_ADD;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SB);
   endfunction

   function automatic logic is_zero_cmp_branch(input logic [5:0] op);
      return (op == OP_BLEZ) || (op == OP_BGTZ) || (op == OP_REGIMM);
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch decision from the SUB result flags; blez/bgtz/bgez compare rs against $0.
module branch_cond
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       neg,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:    taken = zero;
         OP_BNE:    taken = !zero;
         OP_BLEZ:   taken = zero || neg;
         OP_BGTZ:   taken = !zero && !neg;
         OP_REGIMM: taken = !neg;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes and selects from the current state.
module multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       alu_zero,
   input  logic       alu_neg,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       iord,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [5:0] alu_op,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       rt_force_zero,
   output logic       halted,
   output logic       illegal,
   output logic [3:0] state
);

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   br_taken;

   branch_cond u_branch_cond (
      .opcode (opcode),
      .zero   (alu_zero),
      .neg    (alu_neg),
      .taken  (br_taken)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      illegal_d     = illegal_q;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      iord          = 1'b0;
      pc_src        = PC_SRC_ALU;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RT;
      alu_op        = '0;
      reg_dst       = DST_RT;
      mem_to_reg    = M2R_ALUOUT;
      rt_force_zero = 1'b0;
      halted        = 1'b0;
      illegal       = illegal_q;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRC_B_FOUR;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = SRC_B_IMM_SH2;
            alu_op    = ALU_ADD;
            case (classify(opcode))
               IC_RTYPE:  state_d = (func == FN_SYSCALL) ? S_HALT : S_EXEC_R;
               IC_ITYPE:  state_d = S_EXEC_I;
               IC_MEM:    state_d = S_MEM_ADDR;
               IC_BRANCH: state_d = S_BRANCH;
               IC_JUMP:   state_d = S_JUMP;
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_RT;
            alu_op    = func;
            state_d   = S_WB_R;
         end
         S_EXEC_I: begin
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_IMM;
            alu_op    = itype_alu_op(opcode);
            state_d   = S_WB_I;
         end
         S_MEM_ADDR: begin
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_ADD;
            state_d   = is_store(opcode) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) state_d = S_WB_MEM;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_WB_R: begin
            reg_dst   = DST_RD;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_WB_I: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_WB_MEM: begin
            mem_to_reg = M2R_MDR;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = SRC_A_RS;
            alu_src_b     = SRC_B_RT;
            alu_op        = ALU_SUB;
            pc_src        = PC_SRC_ALUOUT;
            rt_force_zero = is_zero_cmp_branch(opcode);
            pc_write      = br_taken;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            if (opcode == OP_JAL) begin
               reg_write  = 1'b1;
               reg_dst    = DST_RA;
               mem_to_reg = M2R_PC;
            end
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // FETCH drives nonzero selects, so reset must also mask outputs combinationally.
      if (!rst_n) begin
         pc_write      = 1'b0;
         ir_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         iord          = 1'b0;
         pc_src        = '0;
         alu_src_a     = 1'b0;
         alu_src_b     = '0;
         alu_op        = '0;
         reg_dst       = '0;
         mem_to_reg    = '0;
         rt_force_zero = 1'b0;
         halted        = 1'b0;
         illegal       = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference model
// expanded into per-cycle expectations, directed vector table plus random traffic.
module tb_multicycle_control;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;
   logic       alu_zero = 1'b0;
   logic       alu_neg = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, ir_write, mem_read, mem_write, reg_write, iord;
   logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
   logic       alu_src_a, rt_force_zero, halted, illegal;
   logic [5:0] alu_op;
   logic [3:0] state;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .func          (func),
      .alu_zero      (alu_zero),
      .alu_neg       (alu_neg),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .ir_write      (ir_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .iord          (iord),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .rt_force_zero (rt_force_zero),
      .halted        (halted),
      .illegal       (illegal),
      .state         (state)
   );

   typedef struct packed {
      logic       pc_write, ir_write, mem_read, mem_write, reg_write, iord;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [5:0] alu_op;
      logic [1:0] reg_dst, mem_to_reg;
      logic       rt_force_zero, halted, illegal;
      logic [3:0] state;
   } out_t;

   out_t act;
   assign act = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                 rt_force_zero, halted, illegal, state};

   typedef enum {T_FETCH, T_DECODE, T_EXR, T_EXI, T_ADDR, T_RD, T_WR,
                 T_WBR, T_WBI, T_WBM, T_BR, T_J, T_HALT} step_t;

   localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_J = 5, C_SYS = 6, C_ILL = 7;

   int checks_total = 0;
   int checks_passed = 0;
   bit illegal_m = 1'b0;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      int         v;
      int         mstall;
      int         exp_cycles;
      bit         exp_halt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                               input int v, input int ms, input int cyc, input bit h);
      vec_t r;
      r.name = n; r.op = op; r.fn = fn; r.v = v; r.mstall = ms; r.exp_cycles = cyc; r.exp_halt = h;
      return r;
   endfunction

   function automatic int tb_class(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return (fn == 6'b001100) ? C_SYS : C_R;
         6'b001000, 6'b001001, 6'b001010, 6'b001100,
         6'b001101, 6'b001110, 6'b001111: return C_I;
         6'b100011, 6'b100000: return C_LD;
         6'b101011, 6'b101000: return C_ST;
         6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: return C_BR;
         6'b000010, 6'b000011: return C_J;
         default: return C_ILL;
      endcase
   endfunction

   // v stands for the signed value rs - rt (or rs - 0) the ALU produced.
   function automatic bit taken_of(input logic [5:0] op, input int v);
      case (op)
         6'b000100: return v == 0;
         6'b000101: return v != 0;
         6'b000110: return v <= 0;
         6'b000111: return v > 0;
         6'b000001: return v >= 0;
         default:   return 1'b0;
      endcase
   endfunction

   function automatic logic [5:0] imm_alu(input logic [5:0] op);
      case (op)
         6'b001000: return ALU_ADD;
         6'b001001: return ALU_ADDU;
         6'b001100: return ALU_AND;
         6'b001101: return ALU_OR;
         6'b001110: return ALU_XOR;
         6'b001010: return ALU_SLT;
         default:   return ALU_LUI;
      endcase
   endfunction

   function automatic out_t model(input step_t s, input logic [5:0] op, input logic [5:0] fn,
                                  input int v, input bit rdy, input bit ill);
      out_t o;
      o = '0;
      o.illegal = ill;
      case (s)
         T_FETCH:  begin o.state = S_FETCH; o.mem_read = 1; o.alu_src_b = 2'd1; o.alu_op = ALU_ADD;
                         o.pc_write = rdy; o.ir_write = rdy; end
         T_DECODE: begin o.state = S_DECODE; o.alu_src_b = 2'd3; o.alu_op = ALU_ADD; end
         T_EXR:    begin o.state = S_EXEC_R; o.alu_src_a = 1; o.alu_op = fn; end
         T_EXI:    begin o.state = S_EXEC_I; o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = imm_alu(op); end
         T_ADDR:   begin o.state = S_MEM_ADDR; o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = ALU_ADD; end
         T_RD:     begin o.state = S_MEM_RD; o.mem_read = 1; o.iord = 1; end
         T_WR:     begin o.state = S_MEM_WR; o.mem_write = 1; o.iord = 1; end
         T_WBR:    begin o.state = S_WB_R; o.reg_write = 1; o.reg_dst = 2'd1; end
         T_WBI:    begin o.state = S_WB_I; o.reg_write = 1; end
         T_WBM:    begin o.state = S_WB_MEM; o.reg_write = 1; o.mem_to_reg = 2'd1; end
         T_BR:     begin o.state = S_BRANCH; o.alu_src_a = 1; o.alu_op = ALU_SUB; o.pc_src = 2'd1;
                         o.rt_force_zero = (op == 6'b000110 || op == 6'b000111 || op == 6'b000001);
                         o.pc_write = taken_of(op, v); end
         T_J:      begin o.state = S_JUMP; o.pc_write = 1; o.pc_src = 2'd2;
                         if (op == 6'b000011) begin o.reg_write = 1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; end
                   end
         default:  begin o.state = S_HALT; o.halted = 1; end
      endcase
      return o;
   endfunction

   task automatic check(input string name, input out_t exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks_total++;
      if (got == exp) checks_passed++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input int v, input bit rdy);
      opcode = op; func = fn; alu_zero = (v == 0); alu_neg = (v < 0); mem_ready = rdy;
   endtask

   // Entered and left at posedge+1; outputs sampled on the falling edge.
   task automatic do_reset(input string tag, input bit rdy);
      out_t z;
      z = '0;
      z.state = S_FETCH;
      mem_ready = rdy;
      rst_n = 1'b0;
      illegal_m = 1'b0;
      #1 check({tag, "/reset_async"}, z);
      @(posedge clk); #1;
      check({tag, "/reset_hold"}, z);
      rst_n = 1'b1;
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input int v, input int fstall, input int mstall,
                            output int cycles, output bit halted_out);
      step_t seq[$];
      int    c;
      int    nwait;
      bit    rdy, waitst;
      c = tb_class(op, fn);
      cycles = 0;
      halted_out = 1'b0;
      seq.push_back(T_FETCH);
      seq.push_back(T_DECODE);
      case (c)
         C_R:  begin seq.push_back(T_EXR); seq.push_back(T_WBR); end
         C_I:  begin seq.push_back(T_EXI); seq.push_back(T_WBI); end
         C_LD: begin seq.push_back(T_ADDR); seq.push_back(T_RD); seq.push_back(T_WBM); end
         C_ST: begin seq.push_back(T_ADDR); seq.push_back(T_WR); end
         C_BR: seq.push_back(T_BR);
         C_J:  seq.push_back(T_J);
         default: seq.push_back(T_HALT);
      endcase
      foreach (seq[i]) begin
         waitst = (seq[i] == T_FETCH || seq[i] == T_RD || seq[i] == T_WR);
         nwait = (seq[i] == T_FETCH) ? fstall : (waitst ? mstall : 0);
         if (seq[i] == T_HALT) begin
            if (c == C_ILL) illegal_m = 1'b1;
            halted_out = 1'b1;
         end
         for (int k = 0; k <= nwait; k++) begin
            rdy = waitst ? (k == nwait) : 1'($urandom_range(0, 1));
            drive(op, fn, v, rdy);
            @(negedge clk);
            check($sformatf("%s/%s", tag, seq[i].name()), model(seq[i], op, fn, v, rdy, illegal_m));
            @(posedge clk); #1;
            if (seq[i] != T_HALT) cycles++;
         end
      end
   endtask

   task automatic check_halt(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         drive(6'($urandom), 6'($urandom), $urandom_range(0, 2) - 1, 1'($urandom_range(0, 1)));
         @(negedge clk);
         check({tag, "/halt_hold"}, model(T_HALT, opcode, func, 0, 1'b0, illegal_m));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int         cyc;
      bit         h;
      logic [5:0] legal_ops [20];
      logic [5:0] op;
      logic [5:0] fn;
      step_t      pre [4];

      legal_ops = '{6'b000000, 6'b000000, 6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
                    6'b001110, 6'b001111, 6'b100011, 6'b100000, 6'b101011, 6'b101000, 6'b000100,
                    6'b000101, 6'b000110, 6'b000111, 6'b000001, 6'b000010, 6'b000011};

      vecs.push_back(mk("add",      6'b000000, 6'b100000,  0, 0, 4, 0));
      vecs.push_back(mk("sub",      6'b000000, 6'b100010,  3, 0, 4, 0));
      vecs.push_back(mk("addi",     6'b001000, 6'b000000,  0, 0, 4, 0));
      vecs.push_back(mk("addiu",    6'b001001, 6'b010101,  1, 0, 4, 0));
      vecs.push_back(mk("andi",     6'b001100, 6'b001100,  0, 0, 4, 0));
      vecs.push_back(mk("slti",     6'b001010, 6'b000000, -1, 0, 4, 0));
      vecs.push_back(mk("lui",      6'b001111, 6'b000000,  0, 0, 4, 0));
      vecs.push_back(mk("lw",       6'b100011, 6'b000000,  0, 0, 5, 0));
      vecs.push_back(mk("lw_stall", 6'b100011, 6'b000000,  0, 3, 8, 0));
      vecs.push_back(mk("lb_stall", 6'b100000, 6'b000000,  0, 1, 6, 0));
      vecs.push_back(mk("sw",       6'b101011, 6'b000000,  0, 0, 4, 0));
      vecs.push_back(mk("sb_stall", 6'b101000, 6'b000000,  0, 2, 6, 0));
      vecs.push_back(mk("beq_t",    6'b000100, 6'b000000,  0, 0, 3, 0));
      vecs.push_back(mk("bne_nt",   6'b000101, 6'b000000,  0, 0, 3, 0));
      vecs.push_back(mk("bne_t",    6'b000101, 6'b000000,  7, 0, 3, 0));
      vecs.push_back(mk("blez_t",   6'b000110, 6'b000000, -1, 0, 3, 0));
      vecs.push_back(mk("bgtz_nt",  6'b000111, 6'b000000,  0, 0, 3, 0));
      vecs.push_back(mk("bgtz_t",   6'b000111, 6'b000000,  4, 0, 3, 0));
      vecs.push_back(mk("bgez_nt",  6'b000001, 6'b000000, -3, 0, 3, 0));
      vecs.push_back(mk("bgez_t",   6'b000001, 6'b000000,  0, 0, 3, 0));
      vecs.push_back(mk("j",        6'b000010, 6'b000000,  0, 0, 3, 0));
      vecs.push_back(mk("jal",      6'b000011, 6'b000000,  0, 0, 3, 0));
      vecs.push_back(mk("syscall",  6'b000000, 6'b001100,  0, 0, 0, 1));
      vecs.push_back(mk("illegal",  6'b111111, 6'b000000,  0, 0, 0, 1));
      vecs.push_back(mk("sltiu",    6'b001011, 6'b000000,  0, 0, 0, 1));

      @(posedge clk); #1;
      do_reset("init", 1'b1);

      foreach (vecs[i]) begin
         run_instr(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].v, 0, vecs[i].mstall, cyc, h);
         check_int({vecs[i].name, "/halted"}, int'(h), int'(vecs[i].exp_halt));
         if (h) begin
            check_halt(vecs[i].name, 20);
            do_reset(vecs[i].name, 1'b1);
         end else begin
            check_int({vecs[i].name, "/latency"}, cyc, vecs[i].exp_cycles);
         end
      end

      // Reset while FETCH is waiting on memory, then a clean fetch afterwards.
      for (int k = 0; k < 2; k++) begin
         drive(6'b000000, 6'b100000, 0, 1'b0);
         @(negedge clk);
         check("fetch_wait", model(T_FETCH, opcode, func, 0, 1'b0, 1'b0));
         @(posedge clk); #1;
      end
      do_reset("fetch_wait", 1'b0);
      run_instr("post_reset_add", 6'b000000, 6'b100000, 0, 0, 0, cyc, h);
      check_int("post_reset_add/latency", cyc, 4);

      // Reset in the middle of a load's memory wait.
      pre = '{T_FETCH, T_DECODE, T_ADDR, T_RD};
      foreach (pre[i]) begin
         drive(6'b100011, 6'b000000, 0, pre[i] != T_RD);
         @(negedge clk);
         check($sformatf("lw_abort/%s", pre[i].name()), model(pre[i], opcode, func, 0, mem_ready, 1'b0));
         @(posedge clk); #1;
      end
      do_reset("lw_abort", 1'b0);
      run_instr("post_abort_sw", 6'b101011, 6'b000000, 0, 1, 1, cyc, h);
      check_int("post_abort_sw/latency", cyc, 6);

      // Random instruction stream with random memory stalls.
      for (int n = 0; n < 200; n++) begin
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 19)];
         fn = 6'($urandom);
         run_instr($sformatf("rnd%0d", n), op, fn, int'($urandom_range(0, 4)) - 2,
                   $urandom_range(0, 3), $urandom_range(0, 3), cyc, h);
         if (h) begin
            check_halt($sformatf("rnd%0d", n), 3);
            do_reset($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)));
         end
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: opcode  in  6  instruction[31:26], sampled from the IR; func  in  6  instruction[5:0].
REQ-004 SHALL: alu_zero  in  1  ALU result == 0; alu_neg  in  1  ALU result[31].
REQ-005 SHALL: mem_ready  in  1  memory completes the current access this cycle.
REQ-006 SHALL: pc_write, ir_write, mem_read, mem_write, reg_write, iord  out  1 each  datapath strobes/selects; iord 0 = PC address, 1 = ALU-out address.
REQ-007 SHALL: pc_src  out  2  0 ALU, 1 ALU-out (branch target), 2 jump target; alu_src_a  out  1  0 PC, 1 rs.
REQ-008 SHALL: alu_src_b  out  2  0 rt, 1 const 4, 2 sign-ext imm, 3 imm<<2; alu_op  out  6  ALU function code.
REQ-009 SHALL: reg_dst  out  2  0 rt, 1 rd, 2 $31; mem_to_reg  out  2  0 ALU-out, 1 MDR, 2 PC.
REQ-010 SHALL: rt_force_zero  out  1  forces register read port B to $0; halted  out  1; illegal  out  1; state  out  4  current state code, debug.

Function
REQ-011 SHALL: use Moore FSM states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT.
REQ-012 SHALL: in FETCH, assert mem_read, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0; assert ir_write and pc_write only in the cycle mem_ready=1, then go to DECODE; otherwise hold FETCH with all outputs unchanged.
REQ-013 SHALL: in DECODE, compute branch target (alu_src_a=0, alu_src_b=3, ADD) and dispatch on opcode: 000000 -> EXEC_R, except func 001100 (syscall) -> HALT; addi/addiu/andi/ori/xori/slti/lui -> EXEC_I; lw/lb/sw/sb -> MEM_ADDR; beq/bne/blez/bgtz/bgez (000001) -> BRANCH; j/jal -> JUMP; any other opcode -> HALT with illegal=1.
REQ-014 SHALL: EXEC_R drive alu_src_a=1, alu_src_b=0, alu_op=func, then WB_R (reg_dst=1, mem_to_reg=0, reg_write=1) -> FETCH.
REQ-015 SHALL: EXEC_I drive alu_src_a=1, alu_src_b=2, alu_op per opcode (ADD, ADDU, AND, OR, XOR, SLT, LUI), then WB_I (reg_dst=0, mem_to_reg=0, reg_write=1) -> FETCH.
REQ-016 SHALL: MEM_ADDR compute rs+imm (ADD), then MEM_RD for loads or MEM_WR for stores; both hold iord=1 and mem_read/mem_write until mem_ready=1; MEM_RD -> WB_MEM (reg_dst=0, mem_to_reg=1, reg_write=1) -> FETCH; MEM_WR -> FETCH.
REQ-017 SHALL: BRANCH drive alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, rt_force_zero=1 for blez/bgtz/bgez; pc_write=1 iff taken: beq zero, bne !zero, blez zero|neg, bgtz !zero&!neg, bgez !neg; then FETCH.
REQ-018 SHALL: JUMP assert pc_write with pc_src=2; for jal also reg_write, reg_dst=2, mem_to_reg=2; then FETCH.
REQ-019 SHALL: HALT be absorbing: all strobes 0, halted=1; only reset exits; illegal sticky until reset.
REQ-020 SHALL: strobes pc_write, ir_write, reg_write, mem_write never assert outside the states listed above; all non-listed outputs 0 in every state.
REQ-021 SHALL: latency with mem_ready=1 always: R/I-type 4 cycles, lw/lb 5, sw/sb 4, branch 3, jump 3.

Reset
REQ-022 SHALL: rst_n=0 immediately force state=FETCH, illegal=0, halted=0 and all strobes 0, including mid-memory-wait; first fetch starts on the first clock edge after rst_n rises.

Structure
REQ-023 SHALL: opcode, func, ALU-op codes, state encodings and select encodings live in shared package mips_pkg, also used by ALU and single-cycle decoder.
REQ-024 SHALL: next-state/output logic stay in one module; branch-condition evaluation SHALL be sub-module branch_cond (opcode, zero, neg -> taken).

Verification
REQ-025 SHALL: add $3,$1,$2 (op 0, func 100000), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; reg_write=1, reg_dst=1 in cycle 4 only.
REQ-026 SHALL: lw with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read/iord=1 constant, reg_write once, total 8 cycles.
REQ-027 SHALL: bne with alu_zero=1 -> pc_write=0; with alu_zero=0 -> pc_write=1, pc_src=1; bgez with alu_neg=1 -> not taken, rt_force_zero=1.
REQ-028 SHALL: jal (000011) -> JUMP cycle shows pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2.
REQ-029 SHALL: opcode 111111 -> HALT, illegal=1, halted=1 persisting 20 cycles; syscall -> HALT, illegal=0.
REQ-030 SHALL: rst_n pulled low during FETCH wait with mem_ready=0 -> outputs zero asynchronously, state=FETCH, fetch restarts after release.
